// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-client RAM arbiter and its round-robin picker.
package ram_arb_pkg;

    localparam int AW_DEF = 3;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    // Index of a client: 0 or 1.
    typedef logic client_t;

endpackage : ram_arb_pkg

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. The last-granted pointer moves only when the
// owner accepts a pick via advance; a tie goes to the client not granted last.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       advance,
    output logic [1:0] pick
);

    client_t last;

    always_comb begin
        pick = 2'b00;
        if (req0 && req1) begin
            pick = (last == 1'b1) ? 2'b01 : 2'b10;
        end else if (req0) begin
            pick = 2'b01;
        end else if (req1) begin
            pick = 2'b10;
        end
    end

    // Out of reset last points at client 1, so client 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= 1'b1;
        end else if (advance && (req0 || req1)) begin
            last <= pick[1];
        end
    end

endmodule : rr_arb2

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer putting two clients onto one single-port RAM;
// at most one RAM access is in flight, read data returns with a one-cycle rvalid.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_data_in,
    output logic          ram_we,
    input  logic [DW-1:0] ram_data_out,
    output logic [1:0]    state_dbg
);

    // Handshake: a client holds reqN with stable we/addr/wdata until it sees gntN
    // (one cycle, the cycle the RAM is driven) or withdraws by dropping reqN;
    // a read completes when rvalidN pulses, rdataN holding the result until the next one.

    state_t     state;
    client_t    owner;
    logic       lat_we;
    logic [1:0] pick;
    logic       advance;

    assign advance   = (state == ST_IDLE);
    assign state_dbg = state;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .req1    (req1),
        .advance (advance),
        .pick    (pick)
    );

    // The winner's request is captured straight into the RAM-side registers so
    // the address, data and write strobe are valid in the ISSUE cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= 1'b0;
            lat_we      <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            ram_address <= '0;
            ram_data_in <= '0;
            ram_we      <= 1'b0;
        end else begin
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            ram_we  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        owner <= pick[1];
                        gnt0  <= pick[0];
                        gnt1  <= pick[1];
                        if (pick[1]) begin
                            lat_we      <= we1;
                            ram_we      <= we1;
                            ram_address <= addr1;
                            ram_data_in <= wdata1;
                        end else begin
                            lat_we      <= we0;
                            ram_we      <= we0;
                            ram_address <= addr0;
                            ram_data_in <= wdata0;
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= lat_we ? ST_IDLE : ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    if (owner) begin
                        rdata1  <= ram_data_out;
                        rvalid1 <= 1'b1;
                    end else begin
                        rdata0  <= ram_data_out;
                        rvalid0 <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
    rvalid_onehot: assert property (@(posedge clk) disable iff (rst) !(rvalid0 && rvalid1));
    we_only_in_issue: assert property (@(posedge clk) disable iff (rst)
        ram_we |-> (state == ST_ISSUE));

endmodule : ram_arbiter

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural synchronous 8x8 RAM attached.
module tb_ram_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, we0, we1;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic [2:0] ram_address;
    logic [7:0] ram_data_in;
    logic       ram_we;
    logic [7:0] ram_data_out;
    logic [1:0] state_dbg;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    ram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .we0          (we0),
        .we1          (we1),
        .addr0        (addr0),
        .addr1        (addr1),
        .wdata0       (wdata0),
        .wdata1       (wdata1),
        .gnt0         (gnt0),
        .gnt1         (gnt1),
        .rvalid0      (rvalid0),
        .rvalid1      (rvalid1),
        .rdata0       (rdata0),
        .rdata1       (rdata1),
        .ram_address  (ram_address),
        .ram_data_in  (ram_data_in),
        .ram_we       (ram_we),
        .ram_data_out (ram_data_out),
        .state_dbg    (state_dbg)
    );

    // Behavioural RAM: data_out is registered from the address of the previous cycle.
    logic [7:0] mem [8];
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        ram_data_out = 8'h00;
    end
    always @(posedge clk) begin
        if (ram_we) mem[ram_address] <= ram_data_in;
        ram_data_out <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    {30'd0, gnt1, gnt0}, 32'd0);
        chk({tag, "_rvalid"}, {30'd0, rvalid1, rvalid0}, 32'd0);
        chk({tag, "_rdata0"}, {24'd0, rdata0}, 32'd0);
        chk({tag, "_rdata1"}, {24'd0, rdata1}, 32'd0);
        chk({tag, "_addr"},   {29'd0, ram_address}, 32'd0);
        chk({tag, "_din"},    {24'd0, ram_data_in}, 32'd0);
        chk({tag, "_we"},     {31'd0, ram_we}, 32'd0);
        chk({tag, "_state"},  {30'd0, state_dbg}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got;
        logic [31:0] e;

        // Reset and idle
        do_reset();
        chk_all_zero("rst");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_we", {31'd0, ram_we}, 32'd0);
            chk("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        end

        // Client 0 writes 0xAA to address 1, then reads it back
        req0 = 1; we0 = 1; addr0 = 3'd1; wdata0 = 8'hAA;
        tick();
        chk("wr_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        chk("wr_addr", {29'd0, ram_address}, 32'd1);
        chk("wr_din", {24'd0, ram_data_in}, 32'hAA);
        chk("wr_we", {31'd0, ram_we}, 32'd1);
        req0 = 0;
        tick();
        chk("wr_done_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("wr_done_we", {31'd0, ram_we}, 32'd0);
        req0 = 1; we0 = 0; addr0 = 3'd1;
        tick();
        chk("rd_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        chk("rd_we", {31'd0, ram_we}, 32'd0);
        chk("rd_addr", {29'd0, ram_address}, 32'd1);
        req0 = 0;
        tick();
        chk("rd_capture_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        tick();
        chk("rd_rvalid0", {30'd0, rvalid1, rvalid0}, 32'd1);
        chk("rd_rdata0", {24'd0, rdata0}, 32'hAA);
        tick();
        chk("rd_rvalid_drop", {30'd0, rvalid1, rvalid0}, 32'd0);
        chk("rd_rdata0_hold", {24'd0, rdata0}, 32'hAA);

        // Simultaneous requests from reset: client 0 write, client 1 read, same address
        do_reset();
        req0 = 1; we0 = 1; addr0 = 3'd2; wdata0 = 8'hCC;
        req1 = 1; we1 = 0; addr1 = 3'd2;
        tick();
        chk("tie_first_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
        chk("tie_first_we", {31'd0, ram_we}, 32'd1);
        req0 = 0;
        tick();
        chk("tie_gap_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        tick();
        chk("tie_second_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        chk("tie_second_addr", {29'd0, ram_address}, 32'd2);
        req1 = 0;
        tick();
        tick();
        chk("raw_rvalid1", {30'd0, rvalid1, rvalid0}, 32'd2);
        chk("raw_rdata1", {24'd0, rdata1}, 32'hCC);

        // Both clients hold requests for eight grants: must alternate 0,1,0,1...
        do_reset();
        for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 32'd1 : 32'd2);
        req0 = 1; we0 = 1; addr0 = 3'd4; wdata0 = 8'h11;
        req1 = 1; we1 = 1; addr1 = 3'd5; wdata1 = 8'h22;
        got = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            tick();
            chk("rr_gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
            if (gnt0 || gnt1) begin
                e = exp_q.pop_front();
                chk("rr_order", {30'd0, gnt1, gnt0}, e);
                got++;
            end
        end
        chk("rr_grant_count", got, 32'd8);
        req0 = 0; req1 = 0;
        tick();
        tick();

        // Reset during CAPTURE aborts the read
        do_reset();
        req1 = 1; we1 = 1; addr1 = 3'd3; wdata1 = 8'hF0;
        tick();
        chk("abort_wr_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        req1 = 0;
        tick();
        req1 = 1; we1 = 0; addr1 = 3'd3;
        tick();
        chk("abort_rd_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        req1 = 0;
        tick();
        chk("abort_in_capture", {30'd0, state_dbg}, 32'd2);
        chk("abort_ram_dout", {24'd0, ram_data_out}, 32'hF0);
        rst = 1;
        tick();
        rst = 0;
        chk_all_zero("abort");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        end

        // Client 0 withdraws before grant while client 1 holds a write
        do_reset();
        req1 = 1; we1 = 1; addr1 = 3'd6; wdata1 = 8'h5A;
        tick();
        chk("wd_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
        chk("wd_addr1", {29'd0, ram_address}, 32'd6);
        req0 = 1; we0 = 0; addr0 = 3'd7;
        tick();
        chk("wd_no_gnt0_a", {31'd0, gnt0}, 32'd0);
        req0 = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("wd_no_gnt0", {31'd0, gnt0}, 32'd0);
            chk("wd_no_c0_addr", {31'd0, (gnt0 | gnt1) && (ram_address == 3'd7)}, 32'd0);
        end
        req1 = 0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_ram_arbiter
